// File: rtl/fifo_push_pop_sched_pkg.sv
// Shared types and default sizing for the FIFO push/pop scheduler.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP
  } sched_op_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 4;
  localparam int DEF_DEPTH   = 4;

endpackage

// File: rtl/fifo_push_pop_sched_if.sv
// Producer/consumer handshake and FIFO pin bundle seen by the scheduler.
interface fifo_push_pop_sched_if
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      pop_req;
  logic                      pop_ack;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [DATA_W-1:0]         fifo_data_in;
  logic [OCC_W-1:0]          occupancy;
  logic                      sched_full;
  logic                      sched_empty;

  modport master (
    input  req, req_data, pop_req,
    output gnt, pop_ack, fifo_push, fifo_pop, fifo_data_in,
           occupancy, sched_full, sched_empty
  );

  modport slave (
    output req, req_data, pop_req,
    input  gnt, pop_ack, fifo_push, fifo_pop, fifo_data_in,
           occupancy, sched_full, sched_empty
  );

endinterface

// File: rtl/fifo_push_pop_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PTR_W-1:0]   idx,
  output logic               found
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_pop_sched.sv
// Push/pop scheduler for a shared FIFO; never strobes push and pop together.
// Define FIFO_SCHED_POP_PRIO_EN to give pops strict priority over pushes.
module fifo_push_pop_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input logic                   clk,
  input logic                   reset,
  fifo_push_pop_sched_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]   ptr_q;
  sched_op_t          last_op_q;
  logic [OCC_W-1:0]   occ_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               pop_ack_q;
  logic               push_q;
  logic               pop_q;
  logic [DATA_W-1:0]  data_q;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_found;
  logic               push_ok;
  logic               pop_ok;
  sched_op_t          op;
  logic [PTR_W-1:0]   next_ptr;

  // A requester still holding req in its grant cycle must not win twice.
  assign eligible = bus.req & ~gnt_q;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (eligible),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    push_ok  = pick_found && (occ_q < OCC_W'(DEPTH));
    pop_ok   = bus.pop_req && (occ_q != '0) && !pop_ack_q;
    op       = OP_IDLE;
    next_ptr = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
`ifdef FIFO_SCHED_POP_PRIO_EN
    if (pop_ok)
      op = OP_POP;
    else if (push_ok)
      op = OP_PUSH;
`else
    if (push_ok && pop_ok)
      op = (last_op_q == OP_PUSH) ? OP_POP : OP_PUSH;
    else if (push_ok)
      op = OP_PUSH;
    else if (pop_ok)
      op = OP_POP;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      last_op_q <= OP_POP;
      occ_q     <= '0;
      gnt_q     <= '0;
      pop_ack_q <= 1'b0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      gnt_q     <= '0;
      pop_ack_q <= 1'b0;
      push_q    <= 1'b0;
      pop_q     <= 1'b0;
      case (op)
        OP_PUSH: begin
          gnt_q     <= pick_onehot;
          push_q    <= 1'b1;
          data_q    <= bus.req_data[pick_idx*DATA_W +: DATA_W];
          ptr_q     <= next_ptr;
          occ_q     <= occ_q + OCC_W'(1);
          last_op_q <= OP_PUSH;
        end
        OP_POP: begin
          pop_ack_q <= 1'b1;
          pop_q     <= 1'b1;
          occ_q     <= occ_q - OCC_W'(1);
          last_op_q <= OP_POP;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.pop_ack      = pop_ack_q;
  assign bus.fifo_push    = push_q;
  assign bus.fifo_pop     = pop_q;
  assign bus.fifo_data_in = data_q;
  assign bus.occupancy    = occ_q;
  assign bus.sched_full   = (occ_q == OCC_W'(DEPTH));
  assign bus.sched_empty  = (occ_q == '0);

endmodule

// File: tb/tb_fifo_push_pop_sched.sv
// Scoreboard bench for fifo_push_pop_sched: randomized producers/consumer vs a queue-level model.
module tb_fifo_push_pop_sched;

  localparam int N      = 4;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;

  typedef struct {
    int               cyc;
    int               op;
    int               idx;
    logic [DATA_W-1:0] data;
    int               occ;
  } exp_t;

  logic clk;
  logic reset;

  fifo_push_pop_sched_if #(.NUM_REQ(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_push_pop_sched #(.NUM_REQ(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Producer/consumer state and the abstract scheduler model.
  bit               pend [N];
  logic [DATA_W-1:0] pdata [N];
  bit               pop_pend;
  int               req_prob;
  int               pop_prob;
  int               m_occ;
  int               m_ptr;
  bit               m_last_push;
  int               m_granted;
  bit               m_acked;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit do_reset);
    exp_t e;
    int   winner;
    int   c;
    int   op;
    bit   push_ok;
    bit   pop_ok;
    if (m_granted >= 0) pend[m_granted] = 1'b0;
    if (m_acked) pop_pend = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && ($urandom_range(99) < req_prob)) begin
        pend[i]  = 1'b1;
        pdata[i] = DATA_W'($urandom);
      end
    end
    if (!pop_pend && ($urandom_range(99) < pop_prob)) pop_pend = 1'b1;
    reset = do_reset;
    for (int i = 0; i < N; i++) begin
      bus.req[i] = pend[i];
      bus.req_data[i*DATA_W +: DATA_W] = pdata[i];
    end
    bus.pop_req = pop_pend;

    e.cyc  = cyc + 1;
    e.op   = 0;
    e.idx  = 0;
    e.data = '0;
    if (do_reset) begin
      m_occ = 0; m_ptr = 0; m_last_push = 1'b0; m_granted = -1; m_acked = 1'b0;
    end else begin
      winner = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (winner < 0 && pend[c] && c != m_granted) winner = c;
      end
      push_ok = (winner >= 0) && (m_occ < DEPTH);
      pop_ok  = pop_pend && (m_occ > 0) && !m_acked;
`ifdef FIFO_SCHED_POP_PRIO_EN
      op = pop_ok ? 2 : (push_ok ? 1 : 0);
`else
      if (push_ok && pop_ok) op = m_last_push ? 2 : 1;
      else op = push_ok ? 1 : (pop_ok ? 2 : 0);
`endif
      m_granted = -1;
      m_acked   = 1'b0;
      e.op = op;
      if (op == 1) begin
        e.idx = winner; e.data = pdata[winner];
        m_occ++; m_ptr = (winner + 1) % N; m_last_push = 1'b1; m_granted = winner;
      end else if (op == 2) begin
        m_occ--; m_last_push = 1'b0; m_acked = 1'b1;
      end
    end
    e.occ = m_occ;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents its registered outputs, match them to the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checkOutput("stale_expectation", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      checkOutput("gnt", int'(bus.gnt), (e.op == 1) ? (1 << e.idx) : 0);
      checkOutput("fifo_push", int'(bus.fifo_push), (e.op == 1) ? 1 : 0);
      checkOutput("fifo_pop", int'(bus.fifo_pop), (e.op == 2) ? 1 : 0);
      checkOutput("pop_ack", int'(bus.pop_ack), (e.op == 2) ? 1 : 0);
      checkOutput("push_pop_overlap", int'(bus.fifo_push && bus.fifo_pop), 0);
      if (e.op == 1) checkOutput("fifo_data_in", int'(bus.fifo_data_in), int'(e.data));
      checkOutput("occupancy", int'(bus.occupancy), e.occ);
      checkOutput("sched_full", int'(bus.sched_full), (e.occ == DEPTH) ? 1 : 0);
      checkOutput("sched_empty", int'(bus.sched_empty), (e.occ == 0) ? 1 : 0);
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = '0;
    end
    pop_pend    = 1'b0;
    m_occ       = 0;
    m_ptr       = 0;
    m_last_push = 1'b0;
    m_granted   = -1;
    m_acked     = 1'b0;
    reset       = 1'b1;
    bus.req     = '0;
    bus.req_data = '0;
    bus.pop_req = 1'b0;

    // Reset with every producer requesting, then fill to full with no pops.
    req_prob = 100; pop_prob = 0;
    repeat (2) applyStimulus(1'b1);
    repeat (8) applyStimulus(1'b0);

    // Consumer streams against a full FIFO: pops and pushes interleave.
    pop_prob = 100;
    repeat (12) applyStimulus(1'b0);

    // Drain through a reset, then guard against popping while empty.
    applyStimulus(1'b1);
    req_prob = 0;
    repeat (6) applyStimulus(1'b0);
    req_prob = 30;
    repeat (6) applyStimulus(1'b0);

    // Random traffic with occasional mid-run resets.
    for (int t = 0; t < 600; t++) begin
      if (t % 150 == 0) begin
        req_prob = $urandom_range(90, 10);
        pop_prob = $urandom_range(90, 10);
      end
      applyStimulus($urandom_range(99) < 2);
    end

    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
